// File: rtl/instruction_compressor_if.sv
// instruction_compressor_if: valid/ready input stream and packed output word bus
interface instruction_compressor_if #(parameter int COUNT_WIDTH = 16);
   logic                   in_valid;
   logic                   in_ready;
   logic [31:0]            in_instruction;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [31:0]            out_word;
   logic                   out_last;
   logic [COUNT_WIDTH-1:0] compressed_count;
   modport master (
      output in_valid, in_instruction, in_last, out_ready,
      input  in_ready, out_valid, out_word, out_last, compressed_count
   );
   modport slave (
      input  in_valid, in_instruction, in_last, out_ready,
      output in_ready, out_valid, out_word, out_last, compressed_count
   );
endinterface

// File: rtl/instruction_compressor.sv
// instruction_compressor: re-encodes RV32I into RVC where possible and packs halfwords into 32-bit words
module instruction_compressor #(
   parameter int          COUNT_WIDTH  = 16,
   parameter logic [15:0] PAD_HALFWORD = 16'h0001
) (
   input logic                      clk,
   input logic                      reset,
   instruction_compressor_if.slave  bus
);
   typedef enum logic [1:0] {EMPTY, HALF, FLUSH} state_t;
   localparam logic [6:0] OP_REG = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   state_t                 r_state, w_state_nxt;
   logic [15:0]            r_pending, w_pending_nxt;
   logic                   r_out_valid, r_out_last, w_last_nxt, w_load;
   logic [31:0]            r_out_word, w_word_nxt;
   logic [COUNT_WIDTH-1:0] r_count;
   logic [31:0]            w_ins;
   logic [6:0]             w_op, w_f7;
   logic [4:0]             w_rd, w_rs1, w_rs2;
   logic [2:0]             w_f3;
   logic                   w_small, w_rv, w_reg, w_imm;
   logic                   w_is_c, w_accept, w_slot_free;
   logic [15:0]            w_c;
   assign w_ins       = bus.in_instruction;
   assign w_op        = w_ins[6:0];
   assign w_rd        = w_ins[11:7];
   assign w_f3        = w_ins[14:12];
   assign w_rs1       = w_ins[19:15];
   assign w_rs2       = w_ins[24:20];
   assign w_f7        = w_ins[31:25];
   assign w_small     = (&w_ins[31:25]) | ~(|w_ins[31:25]);
   assign w_rv        = (w_rd[4:3] == 2'b01) && (w_rs2[4:3] == 2'b01) && (w_rs1 == w_rd);
   assign w_reg       = (w_op == OP_REG) && (w_f7 == 7'b0000000);
   assign w_imm       = (w_op == OP_IMM) && (w_f3 == 3'b000) && (w_rd != 5'd0) && w_small;
   assign w_slot_free = !r_out_valid || bus.out_ready;
   assign w_accept    = bus.in_valid && bus.in_ready;
   assign bus.in_ready         = (r_state != FLUSH) && w_slot_free;
   assign bus.out_valid        = r_out_valid;
   assign bus.out_word         = r_out_word;
   assign bus.out_last         = r_out_last;
   assign bus.compressed_count = r_count;
   // Priority-ordered RVC match on the current input instruction
   always_comb begin
      w_is_c = 1'b1;
      w_c    = 16'h0000;
      if (w_reg && w_f3 == 3'b000 && w_rd != 5'd0 && w_rs2 != 5'd0 && w_rs1 == 5'd0)
         w_c = {3'b100, 1'b0, w_rd, w_rs2, 2'b10};
      else if (w_reg && w_f3 == 3'b000 && w_rd != 5'd0 && w_rs2 != 5'd0 && w_rs1 == w_rd)
         w_c = {3'b100, 1'b1, w_rd, w_rs2, 2'b10};
      else if (w_imm && w_rs1 == 5'd0)
         w_c = {3'b010, w_ins[25], w_rd, w_ins[24:20], 2'b01};
      else if (w_imm && w_rs1 == w_rd && w_ins[31:20] != 12'd0)
         w_c = {3'b000, w_ins[25], w_rd, w_ins[24:20], 2'b01};
      else if (w_op == OP_IMM && w_f3 == 3'b001 && w_f7 == 7'b0000000 && w_rd != 5'd0 && w_rs1 == w_rd && w_rs2 != 5'd0)
         w_c = {3'b000, 1'b0, w_rd, w_rs2, 2'b10};
      else if (w_op == OP_REG && w_rv && w_f3 == 3'b000 && w_f7 == 7'b0100000)
         w_c = {6'b100011, w_rd[2:0], 2'b00, w_rs2[2:0], 2'b01};
      else if (w_reg && w_rv && w_f3 == 3'b100)
         w_c = {6'b100011, w_rd[2:0], 2'b01, w_rs2[2:0], 2'b01};
      else if (w_reg && w_rv && w_f3 == 3'b110)
         w_c = {6'b100011, w_rd[2:0], 2'b10, w_rs2[2:0], 2'b01};
      else if (w_reg && w_rv && w_f3 == 3'b111)
         w_c = {6'b100011, w_rd[2:0], 2'b11, w_rs2[2:0], 2'b01};
      else
         w_is_c = 1'b0;
   end
   // Packer next state: pair halfwords, emit words, and pad a leftover half on flush
   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_load        = 1'b0;
      w_word_nxt    = r_out_word;
      w_last_nxt    = r_out_last;
      if (r_state == FLUSH) begin
         if (w_slot_free) begin
            w_load      = 1'b1;
            w_word_nxt  = {PAD_HALFWORD, r_pending};
            w_last_nxt  = 1'b1;
            w_state_nxt = EMPTY;
         end
      end else if (w_accept) begin
         if (r_state == EMPTY && w_is_c) begin
            w_pending_nxt = w_c;
            w_state_nxt   = bus.in_last ? FLUSH : HALF;
         end else if (r_state == EMPTY) begin
            w_load     = 1'b1;
            w_word_nxt = w_ins;
            w_last_nxt = bus.in_last;
         end else if (w_is_c) begin
            w_load      = 1'b1;
            w_word_nxt  = {w_c, r_pending};
            w_last_nxt  = bus.in_last;
            w_state_nxt = EMPTY;
         end else begin
            w_load        = 1'b1;
            w_word_nxt    = {w_ins[15:0], r_pending};
            w_last_nxt    = 1'b0;
            w_pending_nxt = w_ins[31:16];
            w_state_nxt   = bus.in_last ? FLUSH : HALF;
         end
      end
   end
   // State, pending half, output slot and compressed-instruction counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= EMPTY;
         r_pending   <= 16'h0000;
         r_out_valid <= 1'b0;
         r_out_word  <= 32'h0;
         r_out_last  <= 1'b0;
         r_count     <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_pending   <= w_pending_nxt;
         r_out_valid <= w_load ? 1'b1 : (bus.out_ready ? 1'b0 : r_out_valid);
         r_out_word  <= w_word_nxt;
         r_out_last  <= w_last_nxt;
         r_count     <= r_count + COUNT_WIDTH'(w_accept && w_is_c);
      end
   end
endmodule
